// File: rtl/alto_emulator_ir_prefetch.sv
// Emulator-task instruction unit: IR and skip flag, IR<-/BUSODD/MAGIC decode, DISP bus source,
// and a power-of-two prefetch FIFO feeding IR<- from the memory side.
module alto_emulator_ir_prefetch #(
    parameter int PREFETCH      = 1,
    parameter int QUEUE_DEPTH   = 4,
    parameter int EMULATOR_TASK = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  current_task_i,
    input  logic [2:0]  bs_i,
    input  logic [3:0]  f2_i,
    input  logic        stall_i,
    input  logic [15:0] bus_i,
    output logic [15:0] bus_o,
    output logic [9:0]  modifiers_o,
    input  logic        skip_set_i,
    output logic        skip_o,
    output logic        magic_o,
    output logic        hold_o,
    input  logic        pf_valid_i,
    input  logic [15:0] pf_data_i,
    output logic        pf_ready_o,
    input  logic        flush_i,
    output logic [4:0]  q_count_o,
    output logic [15:0] ir_o
);
    localparam logic [3:0] F2_BUSODD  = 4'd8;
    localparam logic [3:0] F2_MAGIC   = 4'd9;
    localparam logic [3:0] F2_IR_LOAD = 4'd12;
    localparam logic [2:0] BS_DISP    = 3'd7;
    localparam int         AW         = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam bit         PF_EN      = (PREFETCH != 0);

    logic [15:0]   mem_q [QUEUE_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [15:0]   ir_q, ir_d;
    logic          skip_q, skip_d;

    logic        em, irl, ld, load, push, pop;
    logic [15:0] src;

    assign em   = (current_task_i == 4'(EMULATOR_TASK));
    assign irl  = em && (f2_i == F2_IR_LOAD);
    assign ld   = irl && !stall_i;
    assign src  = PF_EN ? mem_q[rd_q] : bus_i;

    // Hold looks only at registered occupancy and flush, never at pf_valid_i.
    assign hold_o     = PF_EN && irl && ((cnt_q == 5'd0) || flush_i) && !rst_i;
    assign load       = ld && !hold_o;
    assign pop        = PF_EN && load;
    assign pf_ready_o = (cnt_q < 5'(QUEUE_DEPTH));
    assign push       = pf_valid_i && pf_ready_o && !flush_i;

    assign magic_o    = em && (f2_i == F2_MAGIC);
    assign ir_o       = ir_q;
    assign skip_o     = skip_q;
    assign q_count_o  = cnt_q;

    always_comb begin
        modifiers_o = 10'd0;
        if (irl && !hold_o) begin
            modifiers_o = {6'b0, src[15], src[10:8]};
        end else if (em && (f2_i == F2_BUSODD)) begin
            modifiers_o = {9'b0, bus_i[15]};
        end
    end

    always_comb begin
        bus_o = 16'hFFFF;
        if (bs_i == BS_DISP) begin
            bus_o[7:0]  = ir_q[7:0];
            bus_o[15:8] = (ir_q[9:8] == 2'b00) ? 8'h00 : {8{ir_q[7]}};
        end
    end

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = wr_q;
            cnt_d = 5'd0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + 5'(push) - 5'(pop);
        end
    end

    always_comb begin
        ir_d   = ir_q;
        skip_d = skip_q;
        if (load) begin
            ir_d   = src;
            skip_d = 1'b0;
        end else if (skip_set_i) begin
            skip_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= 5'd0;
            ir_q   <= 16'd0;
            skip_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            ir_q   <= ir_d;
            skip_q <= skip_d;
        end
    end

    // Storage carries no reset; occupancy alone decides which words are live.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= pf_data_i;
    end
endmodule

// File: tb/tb_alto_emulator_ir_prefetch.sv
// Bench for alto_emulator_ir_prefetch: one PREFETCH=1 and one PREFETCH=0 instance share stimulus;
// a queue-based reference model feeds per-instance scoreboards drained by a negedge monitor.
module tb_alto_emulator_ir_prefetch;
    localparam int DEPTH = 4;
    localparam logic [3:0] IRL = 4'd12, MAG = 4'd9, BOD = 4'd8, IDLE = 4'd0;
    localparam logic [2:0] DISP = 3'd7, BSN = 3'd2;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] bus;
        logic [9:0]  mods;
        logic        skip;
        logic        magic;
        logic        hold;
        logic        ready;
        logic [4:0]  cnt;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  tk_s = '0, f2_s = '0;
    logic [2:0]  bs_s = '0;
    logic        st_s = 1'b0, ss_s = 1'b0, v_s = 1'b0, fl_s = 1'b0;
    logic [15:0] bus_s = '0, d_s = '0;

    logic [15:0] bus1, ir1, bus0, ir0;
    logic [9:0]  mod1, mod0;
    logic        skip1, mag1, hold1, rdy1, skip0, mag0, hold0, rdy0;
    logic [4:0]  cnt1, cnt0;

    int checks = 0, failures = 0;
    exp_t sb1[$], sb0[$];
    logic [15:0] mq1[$], mq0[$];
    logic [15:0] mir[2];
    logic        mskip[2];

    always #5 clk = ~clk;

    alto_emulator_ir_prefetch #(.PREFETCH(1), .QUEUE_DEPTH(DEPTH), .EMULATOR_TASK(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .current_task_i(tk_s), .bs_i(bs_s), .f2_i(f2_s), .stall_i(st_s),
        .bus_i(bus_s), .bus_o(bus1), .modifiers_o(mod1), .skip_set_i(ss_s), .skip_o(skip1),
        .magic_o(mag1), .hold_o(hold1), .pf_valid_i(v_s), .pf_data_i(d_s), .pf_ready_o(rdy1),
        .flush_i(fl_s), .q_count_o(cnt1), .ir_o(ir1));

    alto_emulator_ir_prefetch #(.PREFETCH(0), .QUEUE_DEPTH(DEPTH), .EMULATOR_TASK(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .current_task_i(tk_s), .bs_i(bs_s), .f2_i(f2_s), .stall_i(st_s),
        .bus_i(bus_s), .bus_o(bus0), .modifiers_o(mod0), .skip_set_i(ss_s), .skip_o(skip0),
        .magic_o(mag0), .hold_o(hold0), .pf_valid_i(v_s), .pf_data_i(d_s), .pf_ready_o(rdy0),
        .flush_i(fl_s), .q_count_o(cnt0), .ir_o(ir0));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: expected outputs for the current inputs, then advance one clock.
    task automatic model_cycle(input int p, output exp_t e);
        logic [15:0] q[$];
        logic [15:0] src, ir;
        logic em, irl, hold, ld, push;
        int n;
        if (p == 1) q = mq1; else q = mq0;
        n   = q.size();
        ir  = mir[p];
        em  = (tk_s == 4'd0);
        irl = em && (f2_s == IRL);
        src = (p == 1) ? ((n > 0) ? q[0] : 16'h0000) : bus_s;
        hold = (p == 1) && irl && ((n == 0) || fl_s);
        e.ir    = ir;
        e.skip  = mskip[p];
        e.cnt   = 5'(n);
        e.ready = (n < DEPTH);
        e.hold  = hold;
        e.magic = em && (f2_s == MAG);
        e.mods  = 10'd0;
        if (irl && !hold) e.mods = {6'b0, src[15], src[10:8]};
        else if (em && f2_s == BOD) e.mods = {9'b0, bus_s[15]};
        if (bs_s != DISP) e.bus = 16'hFFFF;
        else if (ir[9:8] == 2'b00) e.bus = {8'h00, ir[7:0]};
        else e.bus = {{8{ir[7]}}, ir[7:0]};
        ld   = irl && !st_s && !hold;
        push = v_s && (n < DEPTH) && !fl_s;
        if (fl_s) q.delete();
        else begin
            if (ld && p == 1) void'(q.pop_front());
            if (push) q.push_back(d_s);
        end
        if (ld) begin
            mir[p] = src;
            mskip[p] = 1'b0;
        end else if (ss_s) mskip[p] = 1'b1;
        if (p == 1) mq1 = q; else mq0 = q;
    endtask

    task automatic cyc(input logic [3:0] tk, input logic [2:0] bs, input logic [3:0] f2,
                       input logic st, input logic [15:0] bus, input logic ss,
                       input logic v, input logic [15:0] d, input logic fl);
        exp_t e1, e0;
        @(posedge clk);
        #1;
        tk_s = tk; bs_s = bs; f2_s = f2; st_s = st; bus_s = bus;
        ss_s = ss; v_s = v; d_s = d; fl_s = fl;
        model_cycle(1, e1);
        sb1.push_back(e1);
        model_cycle(0, e0);
        sb0.push_back(e0);
    endtask

    task automatic model_reset();
        mq1.delete(); mq0.delete();
        mir[0] = 16'h0; mir[1] = 16'h0;
        mskip[0] = 1'b0; mskip[1] = 1'b0;
    endtask

    task automatic rand_cycle();
        logic [3:0] tk, f2;
        int r;
        tk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        r  = $urandom_range(0, 9);
        f2 = (r < 4) ? IRL : (r == 4) ? MAG : (r == 5) ? BOD : 4'($urandom_range(0, 15));
        cyc(tk, 3'($urandom_range(0, 7)), f2, $urandom_range(0, 4) == 0, 16'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6, 16'($urandom),
            $urandom_range(0, 19) == 0);
    endtask

    always @(negedge clk) begin
        if (sb1.size() > 0) begin
            exp_t e;
            e = sb1.pop_front();
            chk("p1_ir", ir1, e.ir);           chk("p1_bus", bus1, e.bus);
            chk("p1_mods", 16'(mod1), 16'(e.mods)); chk("p1_skip", 16'(skip1), 16'(e.skip));
            chk("p1_magic", 16'(mag1), 16'(e.magic)); chk("p1_hold", 16'(hold1), 16'(e.hold));
            chk("p1_ready", 16'(rdy1), 16'(e.ready)); chk("p1_cnt", 16'(cnt1), 16'(e.cnt));
        end
        if (sb0.size() > 0) begin
            exp_t e;
            e = sb0.pop_front();
            chk("p0_ir", ir0, e.ir);           chk("p0_bus", bus0, e.bus);
            chk("p0_mods", 16'(mod0), 16'(e.mods)); chk("p0_skip", 16'(skip0), 16'(e.skip));
            chk("p0_magic", 16'(mag0), 16'(e.magic)); chk("p0_hold", 16'(hold0), 16'(e.hold));
            chk("p0_ready", 16'(rdy0), 16'(e.ready)); chk("p0_cnt", 16'(cnt0), 16'(e.cnt));
        end
    end

    initial begin
        model_reset();
        #3;
        chk("rst_ir", ir1, 16'h0000);   chk("rst_skip", 16'(skip1), 16'h0);
        chk("rst_cnt", 16'(cnt1), 16'h0); chk("rst_ready", 16'(rdy1), 16'h1);
        chk("rst_hold", 16'(hold1), 16'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Two pushes, then IR<- from the head.
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 1, 16'h8A05, 0);
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 1, 16'h0123, 0);
        cyc(0, BSN, IRL,  0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t1_mods", 16'(mod1), 16'h000A); chk("t1_cnt_pre", 16'(cnt1), 16'd2);
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t1_ir", ir1, 16'h8A05); chk("t1_cnt", 16'(cnt1), 16'd1);

        // Empty queue holds IR<-; a pushed word then loads.
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 0, 16'h0, 1);
        cyc(0, BSN, IRL,  0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t2_hold", 16'(hold1), 16'h1);
        cyc(0, BSN, IRL,  0, 16'h0, 0, 1, 16'h4321, 0);
        cyc(0, BSN, IRL,  0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t2_hold_clear", 16'(hold1), 16'h0);

        // Fill to full, offer a fifth word, then pop+push across pointer wrap.
        for (int i = 0; i < 5; i++) cyc(0, BSN, IDLE, 0, 16'h0, 0, 1, 16'h1000 + 16'(i), 0);
        @(negedge clk); #1;
        chk("t3_ready_full", 16'(rdy1), 16'h0);
        for (int i = 0; i < 7; i++) cyc(0, BSN, IRL, 0, 16'h0, 0, 1, 16'h2000 + 16'(i), 0);
        for (int i = 0; i < 5; i++) cyc(0, BSN, IRL, 0, 16'h0, 0, 0, 16'h0, 0);

        // Flush together with push and IR<-.
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 1, 16'h5555, 0);
        cyc(0, BSN, IRL,  0, 16'h0, 0, 1, 16'h6666, 1);
        @(negedge clk); #1;
        chk("t4_hold", 16'(hold1), 16'h1);
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t4_cnt", 16'(cnt1), 16'h0);

        // DISP sign handling.
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 1, 16'h0180, 0);
        cyc(0, BSN, IRL,  0, 16'h0, 0, 1, 16'h0080, 0);
        cyc(0, DISP, IDLE, 0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t5_disp_ff80", bus1, 16'hFF80);
        cyc(0, DISP, IRL, 0, 16'h0, 0, 0, 16'h0, 0);
        cyc(0, DISP, IDLE, 0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t5_disp_0080", bus1, 16'h0080);
        cyc(0, 3'd5, IDLE, 0, 16'h0, 0, 0, 16'h0, 0);

        // Skip set/clear, stalled IR<-, legacy bus load.
        cyc(0, BSN, IDLE, 0, 16'h0, 1, 1, 16'h7777, 0);
        cyc(0, BSN, IRL,  0, 16'h0, 1, 0, 16'h0, 0);
        cyc(0, BSN, IDLE, 0, 16'h0, 1, 1, 16'h7778, 0);
        cyc(0, BSN, IRL,  1, 16'h1234, 0, 0, 16'h0, 0);
        cyc(0, BSN, IRL,  0, 16'h1234, 0, 0, 16'h0, 0);
        cyc(0, BSN, IDLE, 0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk); #1;
        chk("t6_legacy_ir", ir0, 16'h1234);

        for (int i = 0; i < 300; i++) rand_cycle();

        // Asynchronous reset in mid-operation.
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_cnt", 16'(cnt1), 16'h0); chk("arst_ir", ir1, 16'h0);
        chk("arst_ready", 16'(rdy1), 16'h1);
        model_reset();
        tk_s = '0; f2_s = IDLE; v_s = 1'b0; fl_s = 1'b0; ss_s = 1'b0; st_s = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 300; i++) rand_cycle();

        for (int i = 0; i < 4 && (sb1.size() > 0 || sb0.size() > 0); i++) @(negedge clk);
        #1;
        checks++;
        if (sb1.size() > 0 || sb0.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb1.size() + sb0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
